// File: rtl/struct_port_pkg.sv
// Shared types for the struct-port pattern generator: pattern modes, FSM states
// and the lane struct carried on the packed output bus.
package struct_port_pkg;

    localparam int unsigned LANE_MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Data field sized for the widest supported lane; narrower lanes use the LSBs.
    typedef struct packed {
        logic [LANE_MAX_W-1:0] data;
    } lane_t;

endpackage

// File: rtl/patgen_lane.sv
// One output lane: holds the beat currently on the bus, loads the first beat on
// start and steps to the next beat of the selected pattern on each advance.
module patgen_lane
    import struct_port_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] CONST_VAL = '1,
    parameter int unsigned       LANE_IDX  = 0
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_start,
    input  logic  i_adv,
    input  mode_e i_mode,
    output lane_t o_lane
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    function automatic logic [DATA_W-1:0] first_beat(input mode_e m);
        case (m)
            MODE_COUNT: return DATA_W'(LANE_IDX);
            MODE_WALK:  return ONE << (LANE_IDX % DATA_W);
            default:    return CONST_VAL;
        endcase
    endfunction

    // WALK rotates left so lane k lands on bit (k+n) mod DATA_W at beat n.
    function automatic logic [DATA_W-1:0] next_beat(input mode_e m, input logic [DATA_W-1:0] cur);
        case (m)
            MODE_COUNT: return cur + ONE;
            MODE_WALK:  return {cur[DATA_W-2:0], cur[DATA_W-1]};
            MODE_ALT:   return ~cur;
            default:    return cur;
        endcase
    endfunction

    always_comb begin
        data_d = data_q;
        if (i_start) begin
            data_d = first_beat(i_mode);
        end else if (i_adv) begin
            data_d = next_beat(i_mode, data_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    always_comb begin
        o_lane                   = '0;
        o_lane.data[DATA_W-1:0]  = data_q;
    end

endmodule

// File: rtl/struct_port_patgen.sv
// Multi-lane test pattern source with a valid/ready handshake; the FSM and the
// accepted-beat counter live here, per-lane patterns come from patgen_lane.
module struct_port_patgen
    import struct_port_pkg::*;
#(
    parameter int unsigned       NUM_CH    = 2,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] CONST_VAL = '1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [1:0]               i_mode,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic [15:0]              o_count
);

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic        valid_q, valid_d;
    logic        stop_q, stop_d;
    logic [15:0] count_q, count_d;
    logic        start;
    logic        adv;
    logic        accept;
    mode_e       lane_mode;

    lane_t       lane_w [NUM_CH];
    logic [NUM_CH-1:0] unused_lane;

    assign accept = valid_q & i_ready;

    // stop_q remembers an i_en drop seen while a beat was still pending.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        stop_d  = stop_q;
        count_d = count_q;
        start   = 1'b0;
        adv     = 1'b0;
        if (accept && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                stop_d  = 1'b0;
                if (i_en) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    mode_d  = mode_e'(i_mode);
                    count_d = 16'd0;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (!i_en) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    state_d = ST_HOLD;
                    stop_d  = !i_en;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    if (stop_q || !i_en) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        adv     = 1'b1;
                    end
                end else if (!i_en) begin
                    stop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                stop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CONST;
            valid_q <= 1'b0;
            stop_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            stop_q  <= stop_d;
            count_q <= count_d;
        end
    end

    // The start edge uses the incoming mode; every later beat uses the latched one.
    assign lane_mode = start ? mode_e'(i_mode) : mode_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        patgen_lane #(
            .DATA_W    (DATA_W),
            .CONST_VAL (CONST_VAL),
            .LANE_IDX  (k)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_start (start),
            .i_adv   (adv),
            .i_mode  (lane_mode),
            .o_lane  (lane_w[k])
        );
        assign o_data[k*DATA_W +: DATA_W] = lane_w[k].data[DATA_W-1:0];
        assign unused_lane[k]             = ^lane_w[k].data;
    end

    assign o_valid = valid_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_struct_port_patgen.sv
// Directed bench for struct_port_patgen: default instance (CONST_VAL=0xFF) and
// a second instance with CONST_VAL=0xA5 for the alternating pattern.
module tb_struct_port_patgen;

    logic        clk;
    logic        rst_n;
    logic        en_a, ready_a;
    logic [1:0]  mode_a;
    logic        valid_a;
    logic [15:0] data_a;
    logic [15:0] count_a;
    logic        en_b, ready_b;
    logic [1:0]  mode_b;
    logic        valid_b;
    logic [15:0] data_b;
    logic [15:0] count_b;

    int vectors = 0;
    int errs    = 0;

    struct_port_patgen #(.NUM_CH(2), .DATA_W(8)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en_a),
        .i_mode  (mode_a),
        .i_ready (ready_a),
        .o_valid (valid_a),
        .o_data  (data_a),
        .o_count (count_a)
    );

    struct_port_patgen #(.NUM_CH(2), .DATA_W(8), .CONST_VAL(8'hA5)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en_b),
        .i_mode  (mode_b),
        .i_ready (ready_b),
        .o_valid (valid_b),
        .o_data  (data_b),
        .o_count (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] l0, l1;
        rst_n = 1'b0; en_a = 1'b0; mode_a = 2'd0; ready_a = 1'b0;
        en_b = 1'b0; mode_b = 2'd0; ready_b = 1'b0;
        step(); step();
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_data",  32'(data_a),  32'h0);
        chk("rst_count", 32'(count_a), 32'h0);

        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(valid_a), 32'h0);

        // CONST mode, continuous accept
        mode_a = 2'd0; en_a = 1'b1; ready_a = 1'b1;
        step();
        chk("const_first_valid", 32'(valid_a), 32'h1);
        chk("const_first_data",  32'(data_a),  32'hFFFF);
        chk("const_first_count", 32'(count_a), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("const_data",  32'(data_a),  32'hFFFF);
            chk("const_count", 32'(count_a), 32'(i));
        end
        en_a = 1'b0;
        step();
        chk("const_stop_valid", 32'(valid_a), 32'h0);
        chk("const_stop_count", 32'(count_a), 32'd5);
        chk("const_stop_data",  32'(data_a),  32'hFFFF);
        step();
        chk("idle_count_hold", 32'(count_a), 32'd5);

        // COUNT mode, 300 beats
        mode_a = 2'd1; en_a = 1'b1; ready_a = 1'b1;
        step();
        chk("count_first_data",  32'(data_a),  32'h0100);
        chk("count_first_count", 32'(count_a), 32'h0);
        for (int m = 1; m < 300; m++) begin
            step();
            l0 = 8'(m);
            l1 = 8'(m + 1);
            chk("count_data", 32'(data_a), {16'h0, l1, l0});
            if (m == 255) chk("count_lane1_wrap", 32'(data_a[15:8]), 32'h00);
            if (m == 256) chk("count_lane0_wrap", 32'(data_a[7:0]),  32'h00);
        end
        chk("count_total", 32'(count_a), 32'd299);
        en_a = 1'b0;
        step();
        chk("count_stop_valid", 32'(valid_a), 32'h0);
        chk("count_stop_count", 32'(count_a), 32'd300);

        // WALK mode with ready 1,0,0,1
        mode_a = 2'd2; en_a = 1'b1; ready_a = 1'b1;
        step();
        chk("walk_beat0", 32'(data_a), 32'h0201);
        chk("walk_count_clr", 32'(count_a), 32'h0);
        ready_a = 1'b1; step();
        chk("walk_beat1", 32'(data_a), 32'h0402);
        ready_a = 1'b0; step();
        chk("walk_stall1_data",  32'(data_a),  32'h0402);
        chk("walk_stall1_valid", 32'(valid_a), 32'h1);
        ready_a = 1'b0; step();
        chk("walk_stall2_data",  32'(data_a),  32'h0402);
        chk("walk_stall2_valid", 32'(valid_a), 32'h1);
        ready_a = 1'b1; step();
        chk("walk_beat2", 32'(data_a), 32'h0804);
        chk("walk_count", 32'(count_a), 32'd2);

        // i_en dropped during a HOLD stall
        ready_a = 1'b0; step();
        chk("hold_enter_valid", 32'(valid_a), 32'h1);
        en_a = 1'b0; step();
        chk("hold_en0_valid", 32'(valid_a), 32'h1);
        chk("hold_en0_data",  32'(data_a),  32'h0804);
        en_a = 1'b1; step();
        chk("hold_en1_valid", 32'(valid_a), 32'h1);
        en_a = 1'b1; ready_a = 1'b1; step();
        chk("hold_release_valid", 32'(valid_a), 32'h0);
        chk("hold_release_data",  32'(data_a),  32'h0804);
        chk("hold_release_count", 32'(count_a), 32'd3);
        en_a = 1'b0; step();
        chk("hold_idle_valid", 32'(valid_a), 32'h0);

        // Reset in the middle of HOLD
        mode_a = 2'd2; en_a = 1'b1; ready_a = 1'b1;
        step();
        ready_a = 1'b1; step();
        ready_a = 1'b0; step();
        chk("prerst_valid", 32'(valid_a), 32'h1);
        chk("prerst_count", 32'(count_a), 32'd1);
        rst_n = 1'b0; step();
        chk("midrst_valid", 32'(valid_a), 32'h0);
        chk("midrst_data",  32'(data_a),  32'h0);
        chk("midrst_count", 32'(count_a), 32'h0);
        rst_n = 1'b1; en_a = 1'b0; step();
        chk("after_rst_valid", 32'(valid_a), 32'h0);

        // ALT mode on the 0xA5 instance, mode change mid-run ignored
        mode_b = 2'd3; en_b = 1'b1; ready_b = 1'b1;
        step();
        chk("alt_beat0", 32'(data_b), 32'hA5A5);
        chk("alt_valid", 32'(valid_b), 32'h1);
        mode_b = 2'd1; step();
        chk("alt_beat1", 32'(data_b), 32'h5A5A);
        mode_b = 2'd2; step();
        chk("alt_beat2", 32'(data_b), 32'hA5A5);
        chk("alt_count", 32'(count_b), 32'd2);
        en_b = 1'b0; step();
        chk("alt_stop_valid", 32'(valid_b), 32'h0);

        // CONST on the 0xA5 instance after restart latches the new mode
        mode_b = 2'd0; en_b = 1'b1; step();
        chk("constb_beat0", 32'(data_b), 32'hA5A5);
        step();
        chk("constb_beat1", 32'(data_b), 32'hA5A5);
        en_b = 1'b0; step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
